// File: rtl/cpu_pkg.sv
// Types shared between the decoder, the ID/EX control stage and the EX stage:
// ALU operation encodings, the registered control bundle and the stage FSM states.
package cpu_pkg;

  localparam int CPU_REG_AW  = 5;
  localparam int CPU_ALUOP_W = 4;

  typedef enum logic [3:0] {
    ALU_DEFAULT = 4'b0000,
    ALU_ADD     = 4'b0001,
    ALU_SUB     = 4'b0010,
    ALU_AND     = 4'b0011
  } aluop_e;

  // RegDst is consumed at capture time to resolve the destination, so it is not carried into EX.
  typedef struct packed {
    logic regwrite;
    logic memtoreg;
    logic memread;
    logic memwrite;
    logic branch;
    logic alusrc;
  } ex_ctrl_t;

  localparam ex_ctrl_t EX_CTRL_NONE = '0;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } stage_state_e;

endpackage

// File: rtl/id_ex_ctrl_stage_hazard.sv
// Load-use hazard compare: the load sitting in EX writes a register that the
// instruction in ID is about to read.
module lu_hazard_detect #(
  parameter int REG_AW = 5
) (
  input  logic              ex_valid,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_dst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  output logic              hazard
);

  logic rs_match;
  logic rt_match;

  assign rs_match = (ex_dst == id_rs);
  assign rt_match = id_uses_rt && (ex_dst == id_rt);

  // A load into $0 never produces a value worth waiting for.
  assign hazard = ex_valid && ex_memread && (ex_dst != '0) && id_valid && (rs_match || rt_match);

endmodule

// File: rtl/id_ex_ctrl_stage.sv
// ID/EX pipeline register for the control bundle, with load-use bubble insertion,
// branch-flush squash and saturating stall/flush event counters.
module id_ex_ctrl_stage
  import cpu_pkg::*;
#(
  parameter int REG_AW     = CPU_REG_AW,
  parameter int ALUOP_W    = CPU_ALUOP_W,
  parameter int LU_BUBBLES = 1,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic               id_regwrite,
  input  logic               id_memtoreg,
  input  logic               id_memread,
  input  logic               id_memwrite,
  input  logic               id_branch,
  input  logic               id_regdst,
  input  logic               id_alusrc,
  input  logic [ALUOP_W-1:0] id_aluop,
  input  logic [REG_AW-1:0]  id_rs,
  input  logic [REG_AW-1:0]  id_rt,
  input  logic [REG_AW-1:0]  id_rd,
  input  logic               id_uses_rt,
  input  logic               flush,
  output logic               stall_out,
  output logic               ex_valid,
  output logic               ex_regwrite,
  output logic               ex_memtoreg,
  output logic               ex_memread,
  output logic               ex_memwrite,
  output logic               ex_branch,
  output logic               ex_alusrc,
  output logic [ALUOP_W-1:0] ex_aluop,
  output logic [REG_AW-1:0]  ex_rs,
  output logic [REG_AW-1:0]  ex_rt,
  output logic [REG_AW-1:0]  ex_dst,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  localparam logic [2:0]       BCNT_INIT    = 3'(LU_BUBBLES - 1);
  localparam bit               MULTI_BUBBLE = (LU_BUBBLES > 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  stage_state_e      state;
  stage_state_e      state_next;
  logic [2:0]        bcnt;
  logic [2:0]        bcnt_next;
  logic [REG_AW-1:0] hz_dst;
  logic [REG_AW-1:0] hz_dst_next;
  logic              hazard;
  logic              stall;
  logic              take_id;
  logic [REG_AW-1:0] id_dst;

  ex_ctrl_t           ex_ctrl;
  ex_ctrl_t           ctrl_next;
  logic               valid_next;
  logic [ALUOP_W-1:0] aluop_next;
  logic [REG_AW-1:0]  rs_next;
  logic [REG_AW-1:0]  rt_next;
  logic [REG_AW-1:0]  dst_next;

  lu_hazard_detect #(
    .REG_AW(REG_AW)
  ) u_hazard (
    .ex_valid  (ex_valid),
    .ex_memread(ex_ctrl.memread),
    .ex_dst    (ex_dst),
    .id_valid  (id_valid),
    .id_rs     (id_rs),
    .id_rt     (id_rt),
    .id_uses_rt(id_uses_rt),
    .hazard    (hazard)
  );

  // Flush overrides everything; STALL keeps the front end frozen until the bubble budget is spent.
  always_comb begin
    state_next  = state;
    bcnt_next   = bcnt;
    hz_dst_next = hz_dst;
    stall       = 1'b0;
    if (flush) begin
      state_next = RUN;
      bcnt_next  = '0;
    end else begin
      case (state)
        RUN: begin
          if (hazard) begin
            stall       = 1'b1;
            hz_dst_next = ex_dst;
            bcnt_next   = BCNT_INIT;
            if (MULTI_BUBBLE) state_next = STALL;
          end
        end
        STALL: begin
          stall = 1'b1;
          if (bcnt <= 3'd1) begin
            bcnt_next  = '0;
            state_next = RUN;
          end else begin
            bcnt_next = bcnt - 3'd1;
          end
        end
        default: begin
          state_next = RUN;
          bcnt_next  = '0;
        end
      endcase
    end
  end

  assign stall_out = stall;
  assign take_id   = id_valid && !flush && !stall;
  assign id_dst    = id_regdst ? id_rt : id_rd;

  always_comb begin
    valid_next = 1'b0;
    ctrl_next  = EX_CTRL_NONE;
    aluop_next = '0;
    rs_next    = '0;
    rt_next    = '0;
    dst_next   = '0;
    if (take_id) begin
      valid_next         = 1'b1;
      ctrl_next.regwrite = id_regwrite && (id_dst != '0);
      ctrl_next.memtoreg = id_memtoreg;
      ctrl_next.memread  = id_memread;
      ctrl_next.memwrite = id_memwrite;
      ctrl_next.branch   = id_branch;
      ctrl_next.alusrc   = id_alusrc;
      aluop_next         = id_aluop;
      rs_next            = id_rs;
      rt_next            = id_rt;
      dst_next           = id_dst;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RUN;
      bcnt   <= '0;
      hz_dst <= '0;
    end else begin
      state  <= state_next;
      bcnt   <= bcnt_next;
      hz_dst <= hz_dst_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= EX_CTRL_NONE;
      ex_aluop <= '0;
      ex_rs    <= '0;
      ex_rt    <= '0;
      ex_dst   <= '0;
    end else begin
      ex_valid <= valid_next;
      ex_ctrl  <= ctrl_next;
      ex_aluop <= aluop_next;
      ex_rs    <= rs_next;
      ex_rt    <= rt_next;
      ex_dst   <= dst_next;
    end
  end

  assign ex_regwrite = ex_ctrl.regwrite;
  assign ex_memtoreg = ex_ctrl.memtoreg;
  assign ex_memread  = ex_ctrl.memread;
  assign ex_memwrite = ex_ctrl.memwrite;
  assign ex_branch   = ex_ctrl.branch;
  assign ex_alusrc   = ex_ctrl.alusrc;

  // Counters stick at all-ones so a long run never reads back as a small number.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_ONE;
      if (flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_ONE;
    end
  end

  // A stall window is only ever opened by a load with a non-zero destination.
  assert property (@(posedge clk) disable iff (!rst_n) (state == STALL) |-> (hz_dst != '0));

endmodule

// File: tb/tb_id_ex_ctrl_stage.sv
// Directed bench for id_ex_ctrl_stage: a vector stream on a single-bubble instance,
// plus multi-cycle sequences for 3-bubble stalls, flush during stall and counter saturation.
module tb_id_ex_ctrl_stage;

  localparam logic [6:0] C_ADD = 7'b1000000;
  localparam logic [6:0] C_LW  = 7'b1110011;
  localparam logic [6:0] C_SW  = 7'b0001001;
  localparam logic [6:0] C_BEQ = 7'b0000100;
  localparam logic [5:0] E_ADD = 6'b100000;
  localparam logic [5:0] E_LW  = 6'b111001;
  localparam logic [5:0] E_LW0 = 6'b011001;
  localparam logic [5:0] E_SW  = 6'b000101;
  localparam logic [5:0] E_BEQ = 6'b000010;
  localparam int NVEC = 16;

  typedef struct {
    logic       valid;
    logic [6:0] ctl;
    logic [3:0] aluop;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       uses_rt;
    logic       flush;
    logic       exp_stall;
    logic       exp_valid;
    logic [5:0] exp_ctl;
    logic [3:0] exp_aluop;
    logic [4:0] exp_rs;
    logic [4:0] exp_rt;
    logic [4:0] exp_dst;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid = 1'b0;
  logic [6:0] id_ctl = '0;
  logic [3:0] id_aluop = '0;
  logic [4:0] id_rs = '0;
  logic [4:0] id_rt = '0;
  logic [4:0] id_rd = '0;
  logic       id_uses_rt = 1'b0;
  logic       flush = 1'b0;

  wire        a_stall, a_valid;
  wire [5:0]  a_ctl;
  wire [3:0]  a_aluop;
  wire [4:0]  a_rs, a_rt, a_dst;
  wire [15:0] a_stall_cnt, a_flush_cnt;

  wire        b_stall, b_valid;
  wire [5:0]  b_ctl;
  wire [3:0]  b_aluop;
  wire [4:0]  b_rs, b_rt, b_dst;
  wire [15:0] b_stall_cnt, b_flush_cnt;

  wire        s_stall, s_valid;
  wire [5:0]  s_ctl;
  wire [3:0]  s_aluop;
  wire [4:0]  s_rs, s_rt, s_dst;
  wire [3:0]  s_stall_cnt, s_flush_cnt;

  int checks = 0;
  int failures = 0;
  vec_t vecs[NVEC];

  always #5 clk = ~clk;

  id_ex_ctrl_stage #(.REG_AW(5), .ALUOP_W(4), .LU_BUBBLES(1), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_regwrite(id_ctl[6]), .id_memtoreg(id_ctl[5]), .id_memread(id_ctl[4]),
    .id_memwrite(id_ctl[3]), .id_branch(id_ctl[2]), .id_regdst(id_ctl[1]), .id_alusrc(id_ctl[0]),
    .id_aluop(id_aluop), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_uses_rt(id_uses_rt), .flush(flush), .stall_out(a_stall), .ex_valid(a_valid),
    .ex_regwrite(a_ctl[5]), .ex_memtoreg(a_ctl[4]), .ex_memread(a_ctl[3]),
    .ex_memwrite(a_ctl[2]), .ex_branch(a_ctl[1]), .ex_alusrc(a_ctl[0]),
    .ex_aluop(a_aluop), .ex_rs(a_rs), .ex_rt(a_rt), .ex_dst(a_dst),
    .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
  );

  id_ex_ctrl_stage #(.REG_AW(5), .ALUOP_W(4), .LU_BUBBLES(3), .CNT_W(16)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_regwrite(id_ctl[6]), .id_memtoreg(id_ctl[5]), .id_memread(id_ctl[4]),
    .id_memwrite(id_ctl[3]), .id_branch(id_ctl[2]), .id_regdst(id_ctl[1]), .id_alusrc(id_ctl[0]),
    .id_aluop(id_aluop), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_uses_rt(id_uses_rt), .flush(flush), .stall_out(b_stall), .ex_valid(b_valid),
    .ex_regwrite(b_ctl[5]), .ex_memtoreg(b_ctl[4]), .ex_memread(b_ctl[3]),
    .ex_memwrite(b_ctl[2]), .ex_branch(b_ctl[1]), .ex_alusrc(b_ctl[0]),
    .ex_aluop(b_aluop), .ex_rs(b_rs), .ex_rt(b_rt), .ex_dst(b_dst),
    .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
  );

  id_ex_ctrl_stage #(.REG_AW(5), .ALUOP_W(4), .LU_BUBBLES(1), .CNT_W(4)) u_dut_sat (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_regwrite(id_ctl[6]), .id_memtoreg(id_ctl[5]), .id_memread(id_ctl[4]),
    .id_memwrite(id_ctl[3]), .id_branch(id_ctl[2]), .id_regdst(id_ctl[1]), .id_alusrc(id_ctl[0]),
    .id_aluop(id_aluop), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_uses_rt(id_uses_rt), .flush(flush), .stall_out(s_stall), .ex_valid(s_valid),
    .ex_regwrite(s_ctl[5]), .ex_memtoreg(s_ctl[4]), .ex_memread(s_ctl[3]),
    .ex_memwrite(s_ctl[2]), .ex_branch(s_ctl[1]), .ex_alusrc(s_ctl[0]),
    .ex_aluop(s_aluop), .ex_rs(s_rs), .ex_rt(s_rt), .ex_dst(s_dst),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic v, input logic [6:0] ctl, input logic [3:0] op,
                                input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                input logic urt, input logic fl);
    id_valid   = v;
    id_ctl     = ctl;
    id_aluop   = op;
    id_rs      = rs;
    id_rt      = rt;
    id_rd      = rd;
    id_uses_rt = urt;
    flush      = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    apply_stimulus(1'b0, '0, '0, '0, '0, '0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n_stall;
    int n_bubble;
    int guard;

    // valid ctl op rs rt rd urt flush | stall | valid ctl op rs rt dst
    vecs[0]  = '{1'b1, C_ADD, 4'd1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1, E_ADD, 4'd1, 5'd1, 5'd2, 5'd3};
    vecs[1]  = '{1'b1, C_LW,  4'd1, 5'd1, 5'd5, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1, E_LW,  4'd1, 5'd1, 5'd5, 5'd5};
    vecs[2]  = '{1'b1, C_ADD, 4'd1, 5'd5, 5'd2, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0, 6'd0,  4'd0, 5'd0, 5'd0, 5'd0};
    vecs[3]  = '{1'b1, C_ADD, 4'd1, 5'd5, 5'd2, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1, E_ADD, 4'd1, 5'd5, 5'd2, 5'd6};
    vecs[4]  = '{1'b1, C_LW,  4'd1, 5'd2, 5'd0, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1, E_LW0, 4'd1, 5'd2, 5'd0, 5'd0};
    vecs[5]  = '{1'b1, C_ADD, 4'd1, 5'd0, 5'd7, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1, E_ADD, 4'd1, 5'd0, 5'd7, 5'd8};
    vecs[6]  = '{1'b1, C_LW,  4'd1, 5'd1, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, E_LW,  4'd1, 5'd1, 5'd4, 5'd4};
    vecs[7]  = '{1'b1, C_SW,  4'd1, 5'd3, 5'd4, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 6'd0,  4'd0, 5'd0, 5'd0, 5'd0};
    vecs[8]  = '{1'b1, C_SW,  4'd1, 5'd3, 5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, E_SW,  4'd1, 5'd3, 5'd4, 5'd0};
    vecs[9]  = '{1'b1, C_LW,  4'd1, 5'd1, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, E_LW,  4'd1, 5'd1, 5'd4, 5'd4};
    vecs[10] = '{1'b1, C_SW,  4'd1, 5'd3, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, E_SW,  4'd1, 5'd3, 5'd4, 5'd0};
    vecs[11] = '{1'b0, C_ADD, 4'd1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0,  4'd0, 5'd0, 5'd0, 5'd0};
    vecs[12] = '{1'b1, C_LW,  4'd1, 5'd1, 5'd6, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, E_LW,  4'd1, 5'd1, 5'd6, 5'd6};
    vecs[13] = '{1'b1, C_ADD, 4'd1, 5'd6, 5'd1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0,  4'd0, 5'd0, 5'd0, 5'd0};
    vecs[14] = '{1'b1, C_ADD, 4'd1, 5'd6, 5'd1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1, E_ADD, 4'd1, 5'd6, 5'd1, 5'd7};
    vecs[15] = '{1'b1, C_BEQ, 4'd2, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, E_BEQ, 4'd2, 5'd1, 5'd2, 5'd0};

    do_reset();
    check_output("reset_valid", {31'd0, a_valid}, 32'd0);
    check_output("reset_stall_cnt", {16'd0, a_stall_cnt}, 32'd0);

    for (int i = 0; i < NVEC; i++) begin
      apply_stimulus(vecs[i].valid, vecs[i].ctl, vecs[i].aluop, vecs[i].rs, vecs[i].rt,
                     vecs[i].rd, vecs[i].uses_rt, vecs[i].flush);
      #1;
      check_output($sformatf("v%0d_stall", i), {31'd0, a_stall}, {31'd0, vecs[i].exp_stall});
      tick();
      check_output($sformatf("v%0d_valid", i), {31'd0, a_valid}, {31'd0, vecs[i].exp_valid});
      check_output($sformatf("v%0d_ctl", i), {26'd0, a_ctl}, {26'd0, vecs[i].exp_ctl});
      check_output($sformatf("v%0d_aluop", i), {28'd0, a_aluop}, {28'd0, vecs[i].exp_aluop});
      check_output($sformatf("v%0d_rs", i), {27'd0, a_rs}, {27'd0, vecs[i].exp_rs});
      check_output($sformatf("v%0d_rt", i), {27'd0, a_rt}, {27'd0, vecs[i].exp_rt});
      check_output($sformatf("v%0d_dst", i), {27'd0, a_dst}, {27'd0, vecs[i].exp_dst});
    end
    check_output("stream_stall_cnt", {16'd0, a_stall_cnt}, 32'd2);
    check_output("stream_flush_cnt", {16'd0, a_flush_cnt}, 32'd1);

    // Mid-stream asynchronous reset, then the first ADD after release.
    rst_n = 1'b0;
    #1;
    check_output("midrst_valid", {31'd0, a_valid}, 32'd0);
    check_output("midrst_ctl", {26'd0, a_ctl}, 32'd0);
    check_output("midrst_aluop", {28'd0, a_aluop}, 32'd0);
    check_output("midrst_dst", {27'd0, a_dst}, 32'd0);
    check_output("midrst_stall", {31'd0, a_stall}, 32'd0);
    check_output("midrst_stall_cnt", {16'd0, a_stall_cnt}, 32'd0);
    check_output("midrst_flush_cnt", {16'd0, a_flush_cnt}, 32'd0);
    apply_stimulus(1'b1, C_ADD, 4'd1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
    #2;
    rst_n = 1'b1;
    tick();
    check_output("post_rst_valid", {31'd0, a_valid}, 32'd1);
    check_output("post_rst_aluop", {28'd0, a_aluop}, 32'd1);
    check_output("post_rst_dst", {27'd0, a_dst}, 32'd3);
    check_output("post_rst_regwrite", {31'd0, a_ctl[5]}, 32'd1);

    // Three-bubble load-use stall.
    do_reset();
    apply_stimulus(1'b1, C_LW, 4'd1, 5'd1, 5'd5, 5'd0, 1'b0, 1'b0);
    tick();
    apply_stimulus(1'b1, C_ADD, 4'd1, 5'd5, 5'd2, 5'd6, 1'b1, 1'b0);
    #1;
    n_stall = 0;
    n_bubble = 0;
    guard = 0;
    while (b_stall && guard < 10) begin
      n_stall++;
      tick();
      if (!b_valid) n_bubble++;
      #1;
      guard++;
    end
    check_output("lu3_stall_cycles", n_stall, 3);
    check_output("lu3_bubbles", n_bubble, 3);
    check_output("lu3_stall_cnt", {16'd0, b_stall_cnt}, 32'd3);
    tick();
    check_output("lu3_add_valid", {31'd0, b_valid}, 32'd1);
    check_output("lu3_add_dst", {27'd0, b_dst}, 32'd6);

    // Flush arriving while the three-bubble stall is in progress.
    do_reset();
    apply_stimulus(1'b1, C_LW, 4'd1, 5'd1, 5'd5, 5'd0, 1'b0, 1'b0);
    tick();
    apply_stimulus(1'b1, C_ADD, 4'd1, 5'd5, 5'd2, 5'd6, 1'b1, 1'b0);
    #1;
    check_output("fl_hazard_stall", {31'd0, b_stall}, 32'd1);
    tick();
    flush = 1'b1;
    #1;
    check_output("fl_in_stall_stall", {31'd0, b_stall}, 32'd0);
    tick();
    check_output("fl_in_stall_bubble", {31'd0, b_valid}, 32'd0);
    flush = 1'b0;
    #1;
    check_output("fl_back_to_run", {31'd0, b_stall}, 32'd0);
    tick();
    check_output("fl_add_valid", {31'd0, b_valid}, 32'd1);
    check_output("fl_add_dst", {27'd0, b_dst}, 32'd6);
    check_output("fl_flush_cnt", {16'd0, b_flush_cnt}, 32'd1);
    check_output("fl_stall_cnt", {16'd0, b_stall_cnt}, 32'd1);

    // Twenty load-use stalls into a 4-bit counter.
    do_reset();
    for (int k = 0; k < 20; k++) begin
      apply_stimulus(1'b1, C_LW, 4'd1, 5'd1, 5'd5, 5'd0, 1'b0, 1'b0);
      tick();
      apply_stimulus(1'b1, C_ADD, 4'd1, 5'd5, 5'd2, 5'd6, 1'b1, 1'b0);
      tick();
      tick();
    end
    check_output("sat_stall_cnt4", {28'd0, s_stall_cnt}, 32'd15);
    check_output("sat_stall_cnt16", {16'd0, a_stall_cnt}, 32'd20);
    check_output("sat_flush_cnt4", {28'd0, s_flush_cnt}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
